// File: rtl/core_ifq.sv
// core_ifq: instruction fetch queue between fetch and decode.
// Buffers up to DEPTH {pc, instr} pairs, presents them in order to decode
// over valid/ready, halts fetch early enough that the queue never overflows,
// and discards buffered and in-flight words on a pipeline redirect.
module core_ifq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SKID  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  input  logic        if_busy,
  output logic        if_halt,
  input  logic        flush,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  input  logic        id_ready,
  output logic        ovf
);

  localparam int unsigned     PW         = $clog2(DEPTH);
  localparam logic [PW:0]     LP_FULL    = (PW+1)'(DEPTH);
  localparam logic [PW:0]     LP_HALT_AT = (PW+1)'(DEPTH - SKID);
  localparam logic [PW:0]     LP_CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0]   LP_PTR_ONE = PW'(1);

  logic [31:0]   r_pc    [DEPTH];
  logic [31:0]   r_instr [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          r_drop;
  logic          r_ovf;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_wr;

  // Handshake qualification; a push into a full queue is only taken when
  // the head leaves in the same cycle, otherwise the word is lost.
  always_comb begin
    w_push = !if_busy && !flush && !r_drop;
    w_pop  = (r_count != '0) && id_ready && !flush;
    w_full = (r_count == LP_FULL);
    w_wr   = w_push && (!w_full || w_pop);
  end

  // Entry storage; cleared on reset so the head reads as zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
    end else if (w_wr) begin
      r_pc[r_wptr]    <= if_pc;
      r_instr[r_wptr] <= if_instr;
    end
  end

  // Pointers, occupancy, post-redirect drop and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= 1'b1;
    end else begin
      r_drop <= 1'b0;
      if (w_wr)  r_wptr <= r_wptr + LP_PTR_ONE;
      if (w_pop) r_rptr <= r_rptr + LP_PTR_ONE;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign id_valid = (r_count != '0);
  assign id_pc    = r_pc[r_rptr];
  assign id_instr = r_instr[r_rptr];
  assign if_halt  = (r_count >= LP_HALT_AT) || flush;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_core_ifq.sv
// tb_core_ifq: directed and randomized checks of core_ifq against a
// queue-based reference model of the fetch queue.
module tb_core_ifq;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned SKID  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_busy;
  logic        if_halt;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_ready;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [63:0] q[$];
  logic        m_drop = 1'b0;
  logic        m_ovf  = 1'b0;

  core_ifq #(.DEPTH(DEPTH), .SKID(SKID)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_pc    (if_pc),
    .if_instr (if_instr),
    .if_busy  (if_busy),
    .if_halt  (if_halt),
    .flush    (flush),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_instr (id_instr),
    .id_ready (id_ready),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic model_halt();
    return (q.size() >= int'(DEPTH - SKID)) || flush;
  endfunction

  // Check outputs against the model, advance the model with the current
  // inputs, then move one clock edge forward.
  task automatic cyc();
    logic ev;
    logic do_push;
    logic do_pop;
    #1;
    ev = (q.size() != 0);
    chk("id_valid", {31'd0, id_valid}, {31'd0, ev});
    if (ev) begin
      chk("id_pc", id_pc, q[0][63:32]);
      chk("id_instr", id_instr, q[0][31:0]);
    end
    chk("if_halt", {31'd0, if_halt}, {31'd0, model_halt()});
    chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    if (!rst) begin
      q.delete();
      m_drop = 1'b0;
      m_ovf  = 1'b0;
    end else if (flush) begin
      q.delete();
      m_drop = 1'b1;
    end else begin
      do_push = !if_busy && !m_drop;
      do_pop  = ev && id_ready;
      if (do_push && q.size() == int'(DEPTH) && !do_pop) m_ovf = 1'b1;
      else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back({if_pc, if_instr});
      end
      m_drop = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    if_busy  = 1'b0;
    if_pc    = pc;
    if_instr = $urandom;
    cyc();
  endtask

  task automatic idle(input int n);
    if_busy = 1'b1;
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; if_busy = 1'b1; id_ready = 1'b0;
    if_pc = '0; if_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_if_halt", {31'd0, if_halt}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    rst = 1'b1;

    // Fill / drain
    id_ready = 1'b0;
    push(32'h00); push(32'h04); push(32'h08);
    #1;
    chk("fill_halt", {31'd0, if_halt}, 32'd1);
    chk("fill_head", id_pc, 32'h00);
    id_ready = 1'b1;
    idle(4);

    // Streaming
    for (int i = 0; i < 16; i++) begin
      push(32'h100 + 32'(i) * 4);
      chk("stream_halt", {31'd0, if_halt}, 32'd0);
      chk("stream_lag", id_pc, 32'h100 + 32'(i) * 4);
    end
    idle(2);

    // Full with simultaneous push and pop, then overflow
    id_ready = 1'b0;
    push(32'h30); push(32'h34); push(32'h38); push(32'h3C);
    id_ready = 1'b1;
    push(32'h40);
    id_ready = 1'b0;
    push(32'h44);
    #1;
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    idle(2);
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);
    // Drain to two entries, then reset mid-stream with traffic on all inputs
    id_ready = 1'b1;
    idle(2);
    rst = 1'b0; flush = 1'b1; if_busy = 1'b0; if_pc = 32'h500;
    cyc();
    rst = 1'b1; flush = 1'b0; if_busy = 1'b1; id_ready = 1'b0;
    #1;
    chk("mrst_valid", {31'd0, id_valid}, 32'd0);
    chk("mrst_halt", {31'd0, if_halt}, 32'd0);
    chk("mrst_ovf", {31'd0, ovf}, 32'd0);
    cyc();

    // Flush: three queued, pushes at N, N+1, N+2
    push(32'h10); push(32'h14); push(32'h18);
    flush = 1'b1;
    push(32'h200);
    flush = 1'b0;
    push(32'h204);
    push(32'h208);
    if_busy = 1'b1;
    #1;
    chk("flush_first", id_pc, 32'h208);
    chk("flush_valid", {31'd0, id_valid}, 32'd1);
    id_ready = 1'b1;
    idle(2);

    // Randomized backpressure, fetch obeying halt, occasional redirects
    for (int i = 0; i < 400; i++) begin
      id_ready = 1'($urandom_range(0, 1));
      flush    = (i >= 200) && ($urandom_range(0, 24) == 0);
      if_busy  = ($urandom_range(0, 3) == 0) || model_halt();
      if_pc    = 32'h1000 + 32'(i) * 4;
      if_instr = $urandom;
      cyc();
    end
    flush = 1'b0;
    id_ready = 1'b1;
    idle(6);
    chk("rand_no_ovf", {31'd0, ovf}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/core_ifq.md
# core_ifq

Instruction fetch queue between the fetch stage and the decode stage. Captures every fetched word together with its PC, buffers up to DEPTH entries, and presents them in order to decode over a valid/ready handshake. Drives the fetch stage's halt input so the queue never overflows, and discards buffered and in-flight words when the pipeline is redirected.

## Interface
- DEPTH, 4: queue entries; power of two, ≥ 2.
- SKID, 1: free entries held in reserve when asserting fetch halt; 1 ≤ SKID < DEPTH.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- if_pc  in  32  PC of the word on if_instr.
- if_instr  in  instr_t (32)  fetched instruction.
- if_busy  in  1  fetch has no valid word this cycle; word is valid when low.
- if_halt  out  1  stalls the fetch stage.
- flush  in  1  redirect or branch taken; the same cycle pulses set_pc to fetch.
- id_valid  out  1  head entry valid.
- id_pc  out  32  head entry PC.
- id_instr  out  instr_t (32)  head entry instruction.
- id_ready  in  1  decode accepts the head entry this cycle.
- ovf  out  1  sticky overflow error flag.

## Operation
- Storage: circular buffer of DEPTH × {pc, instr}.
  - Write pointer, read pointer: log2(DEPTH) bits, wrap modulo DEPTH.
  - count: log2(DEPTH)+1 bits.
- push = !if_busy && !flush && !drop.
  - drop is a 1-cycle register set by flush, so one extra fetch word is discarded after a redirect (fetch-stage PC lag).
- pop = id_valid && id_ready && !flush.
- Push while count == DEPTH:
  - With a simultaneous pop, the push is accepted and count is unchanged.
  - Without a pop, the word is discarded, storage is unchanged, and ovf sets.
  - ovf clears only on reset.
- Simultaneous push and pop with count in 1..DEPTH-1: both occur and count is unchanged.
- Push into an empty queue: the entry is written and count becomes 1. No combinational bypass to the id_* outputs.
- flush: count := 0, both pointers := 0, id_valid := 0 next cycle; drop := 1.
  - Any push or pop in the flush cycle is ignored.
  - flush in consecutive cycles keeps drop high.
- id_valid = (count != 0), registered-equivalent. id_pc and id_instr are read from the entry at the read pointer.
- While id_valid is high and id_ready is low, id_pc and id_instr hold stable.
- if_halt = (count ≥ DEPTH − SKID) || flush. Computed combinationally from registered count and flush.
- Reset values: count 0, pointers 0, drop 0, ovf 0, id_valid 0, if_halt 0. id_pc and id_instr are 0 (entries cleared).

## Timing
- Latency: a word pushed in cycle N is visible on id_valid/id_pc/id_instr in cycle N+1.
- Throughput: 1 word/cycle in steady state with id_ready high.
- if_halt reflects count at the start of the cycle. A word accepted in the same cycle that if_halt rises lands in the SKID reserve; with SKID ≥ 1, ovf never sets when fetch obeys if_halt.
- flush at cycle N:
  - id_valid is 0 in N+1.
  - Fetch words at N and N+1 are discarded.
  - The first word eligible for capture is at N+2.
- Reset asserted mid-operation empties the queue on the next edge, regardless of flush, push or pop.

## Test plan
- Fill/drain: DEPTH=4, id_ready=0, push PCs 0x00,0x04,0x08 → if_halt high after the 3rd push (count=3). Then id_ready=1 → PCs emerge in order 0x00,0x04,0x08, one per cycle, then id_valid=0.
- Streaming: continuous push of 0x100..0x13C with id_ready=1 → id_pc trails if_pc by exactly 1 cycle, count ≤ 1, if_halt never asserts.
- Full with simultaneous push and pop: count=4, push 0x40 while popping the head → count stays 4, 0x40 is last out, ovf=0. Push without pop at count=4 → word lost, ovf=1 and remains 1.
- Flush: queue holds 3 entries, flush in cycle N with pushes of 0x200 at N and 0x204 at N+1, 0x208 at N+2 → id_valid=0 at N+1; first id_pc seen is 0x208 at N+3.
- Backpressure hold: id_ready toggles 0/1 randomly with continuous pushes → id_pc/id_instr stable whenever id_valid && !id_ready, no reordering or loss, ovf=0.
- Reset mid-stream: rst=0 for one cycle with 2 entries queued → next cycle id_valid=0, if_halt=0, ovf=0, count 0.
